// File: rtl/msrv32_dmem_pkg.sv
// Shared state encoding, access-size codes and store-lane helpers for the
// msrv32 data-memory controller.
package msrv32_dmem_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } dmem_state_t;

  // Access size codes; 2'b11 is treated as a word as well.
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  // Cycles allowed in REQ+RESP before the access is abandoned.
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      HALF:        mis = offset[0];
      WORD, 2'b11: mis = |offset;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b1111;
    case (size)
      BYTE:    mask = 4'b0001 << offset;
      HALF:    mask = 4'b0011 << {offset[1], 1'b0};
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Store data replicated across every lane so the mask alone selects the target bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
    logic [31:0] data;
    data = rs2;
    case (size)
      BYTE:    data = {4{rs2[7:0]}};
      HALF:    data = {2{rs2[15:0]}};
      default: data = rs2;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Combinational load aligner: moves the addressed byte/half/word of a bus
// word down to bit 0 and sign- or zero-extends it to 32 bits.
module msrv32_load_align
  import msrv32_dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Select the access width and extend according to the sign mode.
  always_comb begin
    o_data = w_shifted;
    case (i_size)
      BYTE:    o_data = i_unsigned ? {24'b0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_data = i_unsigned ? {16'b0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory controller between the execute stage and a req/ready +
// rvalid data bus. One access in flight at a time; stores finish on
// acceptance, loads wait for read data. A watchdog abandons accesses that
// spend too long in REQ+RESP and reports a bus error.
module msrv32_dmem_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [4:0]  rd_addr_in,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wr_mask_out,
  output logic        dbus_req_out,
  output logic        dbus_we_out,
  input  logic        dbus_ready_in,
  input  logic        dbus_rvalid_in,
  input  logic [31:0] dbus_rdata_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic [4:0]  rd_addr_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  // The counter saturates at TIMEOUT_CYCLES-1, so it never needs to hold TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // FSM state and the access captured at acceptance.
  dmem_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_store;
  logic [1:0]       r_offset;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [4:0]       r_rd;

  // Registered outputs.
  logic [31:0]      r_dbus_addr;
  logic [31:0]      r_dbus_wdata;
  logic [3:0]       r_dbus_mask;
  logic             r_dbus_req;
  logic             r_dbus_we;
  logic [31:0]      r_load_data;
  logic             r_load_valid;
  logic [4:0]       r_rd_out;
  logic             r_misaligned;
  logic             r_bus_error;

  logic             w_req_any;
  logic             w_is_store;
  logic             w_misaligned;
  logic             w_accept;
  logic             w_cnt_last;
  logic [31:0]      w_aligned_data;

  // A simultaneous read and write request is handled as a store.
  assign w_req_any    = mem_rd_req_in | mem_wr_req_in;
  assign w_is_store   = mem_wr_req_in;
  assign w_misaligned = is_misaligned(load_size_in, iadder_in[1:0]);
  assign w_accept     = (r_state == IDLE) && w_req_any && !w_misaligned;
  assign w_cnt_last   = (r_cnt >= CNT_LAST);

  // Read data is aligned using the offset/size captured with the request.
  msrv32_load_align u_load_align (
    .i_rdata    (dbus_rdata_in),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_aligned_data)
  );

  // Main controller FSM with registered bus and result outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_is_store   <= 1'b0;
      r_offset     <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_rd         <= '0;
      r_dbus_addr  <= '0;
      r_dbus_wdata <= '0;
      r_dbus_mask  <= '0;
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_rd_out     <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_load_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= REQ;
            r_cnt        <= '0;
            r_is_store   <= w_is_store;
            r_offset     <= iadder_in[1:0];
            r_size       <= load_size_in;
            r_unsigned   <= load_unsigned_in;
            r_rd         <= rd_addr_in;
            r_dbus_addr  <= {iadder_in[31:2], 2'b00};
            r_dbus_wdata <= store_data(load_size_in, rs2_in);
            r_dbus_mask  <= w_is_store ? store_mask(load_size_in, iadder_in[1:0]) : 4'b0000;
            r_dbus_we    <= w_is_store;
            r_dbus_req   <= 1'b1;
          end else if (w_req_any) begin
            // Misaligned: report and drop without touching the bus.
            r_misaligned <= 1'b1;
          end
        end

        REQ: begin
          if (!w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // Acceptance takes priority over an expiring timeout.
          if (dbus_ready_in) begin
            r_dbus_req <= 1'b0;
            r_state    <= r_is_store ? DONE : RESP;
          end else if (w_cnt_last) begin
            r_dbus_req  <= 1'b0;
            r_bus_error <= 1'b1;
            r_state     <= ERR;
          end
        end

        RESP: begin
          if (!w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // Read data arriving on the final cycle still completes the load.
          if (dbus_rvalid_in) begin
            r_load_data  <= w_aligned_data;
            r_rd_out     <= r_rd;
            r_load_valid <= 1'b1;
            r_state      <= DONE;
          end else if (w_cnt_last) begin
            r_bus_error <= 1'b1;
            r_state     <= ERR;
          end
        end

        DONE: r_state <= IDLE;
        ERR:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Hold upstream while an access is outstanding or about to be accepted.
  assign stall_out = !reset_in &&
                     ((r_state == REQ) || (r_state == RESP) || w_accept);

  assign dbus_addr_out    = r_dbus_addr;
  assign dbus_wdata_out   = r_dbus_wdata;
  assign dbus_wr_mask_out = r_dbus_mask;
  assign dbus_req_out     = r_dbus_req;
  assign dbus_we_out      = r_dbus_we;
  assign load_data_out    = r_load_data;
  assign load_valid_out   = r_load_valid;
  assign rd_addr_out      = r_rd_out;
  assign misaligned_out   = r_misaligned;
  assign bus_error_out    = r_bus_error;

endmodule
